// File: rtl/test_pattern_gen_pkg.sv
// ============================================================================
// test_pattern_gen_pkg : pattern mode codes, on/off colour indices, bar tables
// Revision: 1.0
// ============================================================================
`default_nettype none

package test_pattern_gen_pkg;

  typedef enum logic [2:0] {
    TPG_BARS    = 3'd0,
    TPG_TIERS   = 3'd1,
    TPG_CHECKER = 3'd2,
    TPG_RAMP    = 3'd3,
    TPG_FRAME   = 3'd4,
    TPG_WHITE   = 3'd5,
    TPG_BLACK   = 3'd6,
    TPG_RSVD    = 3'd7
  } tpg_mode_e;

  // {r,g,b}, each bit selects 0 or full scale on that channel
  typedef logic [2:0] rgb3_t;

  localparam rgb3_t C_BLACK   = 3'b000;
  localparam rgb3_t C_BLUE    = 3'b001;
  localparam rgb3_t C_GREEN   = 3'b010;
  localparam rgb3_t C_CYAN    = 3'b011;
  localparam rgb3_t C_RED     = 3'b100;
  localparam rgb3_t C_MAGENTA = 3'b101;
  localparam rgb3_t C_YELLOW  = 3'b110;
  localparam rgb3_t C_WHITE   = 3'b111;

  localparam int NUM_BARS = 7;

  function automatic rgb3_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      default: return C_BLUE;
    endcase
  endfunction

  function automatic rgb3_t castle_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_BLUE;
      3'd2:    return C_MAGENTA;
      3'd4:    return C_CYAN;
      3'd6:    return C_WHITE;
      default: return C_BLACK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/test_pattern_gen_if.sv
// ============================================================================
// test_pattern_gen_if : pattern control inputs and registered video outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface test_pattern_gen_if #(
  parameter int COLOR_BITS = 2
);
  logic [2:0]            mode;
  logic                  scroll_en;
  logic                  scroll_dir;
  logic [3:0]            scroll_step;
  logic                  hsync;
  logic                  vsync;
  logic                  display_on;
  logic [COLOR_BITS-1:0] r;
  logic [COLOR_BITS-1:0] g;
  logic [COLOR_BITS-1:0] b;
  logic [15:0]           frame_count;

  modport master (
    input  mode, scroll_en, scroll_dir, scroll_step,
    output hsync, vsync, display_on, r, g, b, frame_count
  );

  modport slave (
    output mode, scroll_en, scroll_dir, scroll_step,
    input  hsync, vsync, display_on, r, g, b, frame_count
  );
endinterface

`default_nettype wire

// File: rtl/test_pattern_gen_video_timing.sv
// ============================================================================
// test_pattern_gen_video_timing : h/v counters, raw syncs, active flag, frame start
// Revision: 1.0
// ============================================================================
`default_nettype none

module test_pattern_gen_video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          active,
  output logic          frame_start
);
  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic SP      = (SYNC_POL != 0);

  logic h_last;
  logic v_last;

  assign h_last = (h == HW'(H_TOTAL - 1));
  assign v_last = (v == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign frame_start = h_last && v_last;
  assign active      = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
  assign hsync_raw   = (h >= HW'(H_ACTIVE + H_FP) && h < HW'(H_ACTIVE + H_FP + H_SYNC)) ? SP : ~SP;
  assign vsync_raw   = (v >= VW'(V_ACTIVE + V_FP) && v < VW'(V_ACTIVE + V_FP + V_SYNC)) ? SP : ~SP;

endmodule

`default_nettype wire

// File: rtl/test_pattern_gen.sv
// ============================================================================
// test_pattern_gen : scrollable multi-pattern video source with own timing
// Revision: 1.0
// ============================================================================
`default_nettype none

module test_pattern_gen
  import test_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int COLOR_BITS = 2,
  parameter int CHECK_LOG2 = 5
) (
  input logic               clk,
  input logic               reset,
  test_pattern_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int OW      = $clog2(H_ACTIVE);
  localparam int AW      = HW + 1;

  localparam logic                  SP       = (SYNC_POL != 0);
  localparam logic [COLOR_BITS-1:0] MAX      = {COLOR_BITS{1'b1}};
  localparam logic [COLOR_BITS-1:0] HALF     = MAX >> 1;
  localparam logic [AW-1:0]         HA       = AW'(H_ACTIVE);
  localparam logic [AW-1:0]         RAMP_INC = AW'(2 ** COLOR_BITS);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          hsync_raw, vsync_raw, active, frame_start;

  test_pattern_gen_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .HW(HW), .VW(VW)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .h          (h),
    .v          (v),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .active     (active),
    .frame_start(frame_start)
  );

  tpg_mode_e             mode_q;
  logic                  en_q, dir_q;
  logic [3:0]            step_q;
  logic [OW-1:0]         offset, offset_nxt;
  logic [AW-1:0]         off_rem, rem_nxt;
  logic [COLOR_BITS-1:0] off_lvl, lvl_nxt;
  logic [AW-1:0]         ofs_sum, step_sh, rem_sum;
  logic                  scroll_upd;

  assign scroll_upd = frame_start && en_q;

  // off_rem/off_lvl track (offset * 2**COLOR_BITS) as remainder/quotient of H_ACTIVE,
  // seeding the grey-ramp step counter at the start of each line.
  always_comb begin
    ofs_sum    = AW'(offset) + AW'(step_q);
    step_sh    = AW'(step_q) << COLOR_BITS;
    rem_sum    = off_rem + step_sh;
    offset_nxt = offset;
    rem_nxt    = off_rem;
    lvl_nxt    = off_lvl;
    if (!dir_q) begin
      offset_nxt = (ofs_sum >= HA) ? OW'(ofs_sum - HA) : OW'(ofs_sum);
      if (rem_sum >= HA) begin
        rem_nxt = rem_sum - HA;
        lvl_nxt = off_lvl + 1'b1;
      end else begin
        rem_nxt = rem_sum;
      end
    end else begin
      offset_nxt = (AW'(offset) < AW'(step_q)) ? OW'(AW'(offset) + HA - AW'(step_q))
                                                 : offset - OW'(step_q);
      if (off_rem < step_sh) begin
        rem_nxt = off_rem + HA - step_sh;
        lvl_nxt = off_lvl - 1'b1;
      end else begin
        rem_nxt = off_rem - step_sh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q          <= TPG_BARS;
      en_q            <= 1'b0;
      dir_q           <= 1'b0;
      step_q          <= '0;
      offset          <= '0;
      off_rem         <= '0;
      off_lvl         <= '0;
      bus.frame_count <= '0;
    end else if (frame_start) begin
      mode_q          <= tpg_mode_e'(bus.mode);
      en_q            <= bus.scroll_en;
      dir_q           <= bus.scroll_dir;
      step_q          <= bus.scroll_step;
      bus.frame_count <= bus.frame_count + 16'd1;
      if (en_q) begin
        offset  <= offset_nxt;
        off_rem <= rem_nxt;
        off_lvl <= lvl_nxt;
      end
    end
  end

  logic [AW-1:0]         ramp_acc, ramp_sum;
  logic [COLOR_BITS-1:0] ramp_lvl;

  assign ramp_sum = ramp_acc + RAMP_INC;

  // Level wraps naturally to 0 when sx wraps, since H_ACTIVE maps to exactly 2**COLOR_BITS.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_acc <= '0;
      ramp_lvl <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      ramp_acc <= scroll_upd ? rem_nxt : off_rem;
      ramp_lvl <= scroll_upd ? lvl_nxt : off_lvl;
    end else if (ramp_sum >= HA) begin
      ramp_acc <= ramp_sum - HA;
      ramp_lvl <= ramp_lvl + 1'b1;
    end else begin
      ramp_acc <= ramp_sum;
    end
  end

  logic [AW-1:0]         hx, sx;
  logic [2:0]            bar;
  rgb3_t                 color;
  logic                  grey_sel;
  logic [COLOR_BITS-1:0] grey, pix_r, pix_g, pix_b;

  assign hx = AW'(h) + AW'(offset);
  assign sx = (hx >= HA) ? hx - HA : hx;

  always_comb begin
    bar = '0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (int'(sx) >= (k * H_ACTIVE) / NUM_BARS) bar = 3'(k);
    end
    color    = C_BLACK;
    grey_sel = 1'b0;
    grey     = '0;
    case (mode_q)
      TPG_BARS: color = bar_color(bar);
      TPG_TIERS: begin
        if (int'(v) < 2 * V_ACTIVE / 3)      color = bar_color(bar);
        else if (int'(v) < 3 * V_ACTIVE / 4) color = castle_color(bar);
        else if (int'(h) < H_ACTIVE / 4)     color = C_WHITE;
        else if (int'(h) >= H_ACTIVE / 2 && int'(h) < 3 * H_ACTIVE / 4) begin
          grey_sel = 1'b1;
          grey     = HALF;
        end
      end
      TPG_CHECKER: color = ((((32'(sx) ^ 32'(v)) >> CHECK_LOG2) & 32'd1) != 32'd0) ? C_WHITE : C_BLACK;
      TPG_RAMP: begin
        grey_sel = 1'b1;
        grey     = ramp_lvl;
      end
      TPG_FRAME: begin
        if (int'(h) == 0 || int'(h) == H_ACTIVE - 1 || int'(h) == H_ACTIVE / 2 ||
            int'(v) == 0 || int'(v) == V_ACTIVE - 1 || int'(v) == V_ACTIVE / 2)
          color = C_WHITE;
      end
      TPG_WHITE: color = C_WHITE;
      default:   color = C_BLACK;
    endcase
    pix_r = grey_sel ? grey : (color[2] ? MAX : '0);
    pix_g = grey_sel ? grey : (color[1] ? MAX : '0);
    pix_b = grey_sel ? grey : (color[0] ? MAX : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.hsync      <= ~SP;
      bus.vsync      <= ~SP;
      bus.display_on <= 1'b0;
      bus.r          <= '0;
      bus.g          <= '0;
      bus.b          <= '0;
    end else begin
      bus.hsync      <= hsync_raw;
      bus.vsync      <= vsync_raw;
      bus.display_on <= active;
      bus.r          <= active ? pix_r : '0;
      bus.g          <= active ? pix_g : '0;
      bus.b          <= active ? pix_b : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_test_pattern_gen.sv
// ============================================================================
// tb_test_pattern_gen : directed checks of timing, patterns, scrolling and reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_test_pattern_gen;
  // Horizontal timing at defaults; short vertical timing keeps frames at 800x16 clocks.
  localparam int HT = 800;
  localparam int VT = 16;
  localparam int F  = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  test_pattern_gen_if #(.COLOR_BITS(2)) bus();

  test_pattern_gen #(
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  logic [5:0] rgb;
  assign rgb = {bus.r, bus.g, bus.b};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;
  bit stats_en = 1'b1;
  int hs_cnt = 0, hs_first = -1, vs_cnt = 0, vs_first = -1, mon_err = 0;

  int bar_h [13] = '{90, 91, 181, 182, 273, 274, 364, 365, 456, 457, 547, 548, 639};
  int bar_c [13] = '{'h3f, 'h3c, 'h3c, 'h0f, 'h0f, 'h0c, 'h0c, 'h33, 'h33, 'h30, 'h30, 'h03, 'h03};
  int rmp_h [10] = '{0, 2, 3, 162, 163, 322, 323, 482, 483, 639};
  int rmp_c [10] = '{'h3f, 'h3f, 'h00, 'h00, 'h15, 'h15, 'h2a, 'h2a, 'h3f, 'h3f};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; cyc is the index of the pixel now shown on the outputs.
  task automatic tick();
    int  h, v;
    logic de, hs, vs;
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en) begin
      h  = cyc % HT;
      v  = (cyc / HT) % VT;
      de = (h < 640) && (v < 12);
      hs = !(h >= 656 && h < 752);
      vs = !(v >= 13 && v < 15);
      if (bus.display_on !== de || bus.hsync !== hs || bus.vsync !== vs ||
          (bus.display_on !== 1'b1 && rgb !== 6'd0))
        mon_err++;
      if (stats_en && cyc < HT && bus.hsync === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = h;
      end
      if (stats_en && cyc < F && h == 0 && bus.vsync === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = v;
      end
    end
  endtask

  task automatic run_to(input int f, input int h, input int v);
    int target;
    target = f * F + v * HT + h;
    if (target < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_to: position %0d already passed (cyc %0d)", target, cyc);
    end
    while (cyc < target) tick();
  endtask

  task automatic pix(input string tag, input int f, input int h, input int v, input int exp);
    run_to(f, h, v);
    check_eq(tag, 32'(rgb), 32'(exp));
  endtask

  initial begin
    bus.mode        = 3'd0;
    bus.scroll_en   = 1'b0;
    bus.scroll_dir  = 1'b0;
    bus.scroll_step = 4'd0;
    reset           = 1'b1;
    repeat (3) tick();
    check_eq("rst_disp", 32'(bus.display_on), 0);
    check_eq("rst_hs", 32'(bus.hsync), 1);
    check_eq("rst_vs", 32'(bus.vsync), 1);
    check_eq("rst_rgb", 32'(rgb), 0);
    check_eq("rst_fc", 32'(bus.frame_count), 0);

    reset  = 1'b0;
    cyc    = -1;
    mon_en = 1'b1;
    tick();
    check_eq("px00", 32'(rgb), 'h3f);
    check_eq("px00_disp", 32'(bus.display_on), 1);

    // Frame 0: bars; mid-frame writes must not show until next frame
    pix("pre_wr", 0, 200, 5, 'h0f);
    bus.mode        = 3'd2;
    bus.scroll_en   = 1'b1;
    bus.scroll_dir  = 1'b1;
    bus.scroll_step = 4'd3;
    for (int i = 0; i < 13; i++) pix($sformatf("bar_h%0d", bar_h[i]), 0, bar_h[i], 10, bar_c[i]);
    pix("post_wr", 0, 0, 11, 'h3f);
    run_to(0, 798, 15);
    check_eq("fc_before", 32'(bus.frame_count), 0);
    tick();
    check_eq("fc_after", 32'(bus.frame_count), 1);

    // Frame 1: checkerboard, offset still 0
    run_to(1, 0, 0);
    check_eq("hs_width", hs_cnt, 96);
    check_eq("hs_start", hs_first, 656);
    check_eq("vs_lines", vs_cnt, 2);
    check_eq("vs_start", vs_first, 13);
    stats_en = 1'b0;
    pix("chk_0", 1, 0, 0, 'h00);
    pix("chk_31", 1, 31, 0, 'h00);
    pix("chk_32", 1, 32, 0, 'h3f);
    pix("chk_64", 1, 64, 0, 'h00);
    pix("chk_96", 1, 96, 3, 'h3f);
    bus.mode        = 3'd3;
    bus.scroll_dir  = 1'b0;
    bus.scroll_step = 4'd15;

    // Frame 2: ramp, offset 0-3 -> 637
    for (int i = 0; i < 10; i++) pix($sformatf("ramp_h%0d", rmp_h[i]), 2, rmp_h[i], 2, rmp_c[i]);
    bus.mode      = 3'd1;
    bus.scroll_en = 1'b0;

    // Frame 3: three-tier, offset 637+15 -> 12
    pix("t_bar0", 3, 0, 0, 'h3f);
    pix("t_bar78", 3, 78, 0, 'h3f);
    pix("t_bar79", 3, 79, 0, 'h3c);
    pix("t_bar627", 3, 627, 0, 'h03);
    pix("t_bar628", 3, 628, 0, 'h3f);
    pix("t_cas0", 3, 0, 8, 'h03);
    pix("t_cas79", 3, 79, 8, 'h00);
    pix("t_cas170", 3, 170, 8, 'h33);
    pix("t_cas627", 3, 627, 8, 'h3f);
    pix("t_low0", 3, 0, 9, 'h3f);
    pix("t_low159", 3, 159, 9, 'h3f);
    pix("t_low160", 3, 160, 9, 'h00);
    pix("t_low320", 3, 320, 9, 'h15);
    pix("t_low479", 3, 479, 9, 'h15);
    pix("t_low480", 3, 480, 9, 'h00);
    bus.mode = 3'd4;

    // Frame 4: outline / centre cross
    pix("f_v0", 4, 5, 0, 'h3f);
    pix("f_h0", 4, 0, 3, 'h3f);
    pix("f_h1", 4, 1, 3, 'h00);
    pix("f_h320", 4, 320, 3, 'h3f);
    pix("f_h321", 4, 321, 3, 'h00);
    pix("f_h638", 4, 638, 3, 'h00);
    pix("f_h639", 4, 639, 3, 'h3f);
    pix("f_v5", 4, 5, 5, 'h00);
    pix("f_v6", 4, 5, 6, 'h3f);
    run_to(4, 300, 7);
    check_eq("fc_4", 32'(bus.frame_count), 4);

    // One-cycle reset mid-frame
    reset  = 1'b1;
    mon_en = 1'b0;
    tick();
    check_eq("mr_disp", 32'(bus.display_on), 0);
    check_eq("mr_rgb", 32'(rgb), 0);
    check_eq("mr_sync", 32'({bus.hsync, bus.vsync}), 3);
    check_eq("mr_fc", 32'(bus.frame_count), 0);
    reset  = 1'b0;
    cyc    = -1;
    mon_en = 1'b1;
    tick();
    check_eq("mr_px00", 32'(rgb), 'h3f);
    check_eq("mr_fc0", 32'(bus.frame_count), 0);
    pix("mr_bar91", 0, 91, 0, 'h3c);
    pix("mr_v11", 0, 5, 11, 'h3f);
    run_to(0, 700, 12);
    check_eq("monitor", mon_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
